// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core (fixed priority) and a debug port,
// 0-cycle grant, response 1 cycle after accept; the loser sees ready=0 and a starvation counter forces debug in.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                core_req_valid,
    output logic                core_req_ready,
    input  logic                core_req_we,
    input  logic [ADDR_W-1:0]   core_req_addr,
    input  logic [DATA_W-1:0]   core_req_wdata,
    input  logic [DATA_W/8-1:0] core_req_wmask,
    output logic                core_rsp_valid,
    output logic [DATA_W-1:0]   core_rsp_rdata,

    input  logic                dbg_req_valid,
    output logic                dbg_req_ready,
    input  logic                dbg_req_we,
    input  logic [ADDR_W-1:0]   dbg_req_addr,
    input  logic [DATA_W-1:0]   dbg_req_wdata,
    input  logic [DATA_W/8-1:0] dbg_req_wmask,
    output logic                dbg_rsp_valid,
    output logic [DATA_W-1:0]   dbg_rsp_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rsp_pend_q, rsp_pend_d;
    logic       rsp_owner_q, rsp_owner_d;
    logic       rsp_is_rd_q, rsp_is_rd_d;
    logic       grant_core, grant_dbg;
    logic       unused_addr_lsbs;

    // Byte offset within the word is ignored; lanes come from wmask alone.
    assign unused_addr_lsbs = ^{core_req_addr[1:0], dbg_req_addr[1:0]};

    always_comb begin
        grant_core = 1'b0;
        grant_dbg  = 1'b0;
        if (rst) begin
            if (dbg_req_valid && (wait_cnt_q == WAIT_LIMIT)) begin
                grant_dbg = 1'b1;
            end else if (core_req_valid) begin
                grant_core = 1'b1;
            end else if (dbg_req_valid) begin
                grant_dbg = 1'b1;
            end
        end
    end

    assign core_req_ready = grant_core;
    assign dbg_req_ready  = grant_dbg;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (grant_core) begin
            mem_en    = 1'b1;
            mem_we    = core_req_we;
            mem_addr  = core_req_addr[ADDR_W-1:2];
            mem_wdata = core_req_wdata;
            mem_wmask = core_req_wmask;
        end else if (grant_dbg) begin
            mem_en    = 1'b1;
            mem_we    = dbg_req_we;
            mem_addr  = dbg_req_addr[ADDR_W-1:2];
            mem_wdata = dbg_req_wdata;
            mem_wmask = dbg_req_wmask;
        end
    end

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        rsp_pend_d  = grant_core | grant_dbg;
        rsp_owner_d = rsp_owner_q;
        rsp_is_rd_d = rsp_is_rd_q;
        if (!dbg_req_valid || grant_dbg) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        // Owner tag steers the next-cycle memory data back to the requester.
        if (rsp_pend_d) begin
            rsp_owner_d = grant_dbg;
            rsp_is_rd_d = !mem_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q  <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_is_rd_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_is_rd_q <= rsp_is_rd_d;
        end
    end

    always_comb begin
        core_rsp_valid = 1'b0;
        core_rsp_rdata = '0;
        dbg_rsp_valid  = 1'b0;
        dbg_rsp_rdata  = '0;
        if (rsp_pend_q) begin
            if (rsp_owner_q) begin
                dbg_rsp_valid = 1'b1;
                dbg_rsp_rdata = rsp_is_rd_q ? mem_rdata : '0;
            end else begin
                core_rsp_valid = 1'b1;
                core_rsp_rdata = rsp_is_rd_q ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of directed vectors, hand sequences for reset and starvation,
// then random traffic against a word-array reference model.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid, core_req_ready, core_req_we;
    logic [31:0] core_req_addr, core_req_wdata;
    logic [3:0]  core_req_wmask;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        dbg_req_valid, dbg_req_ready, dbg_req_we;
    logic [31:0] dbg_req_addr, dbg_req_wdata;
    logic [3:0]  dbg_req_wmask;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    logic        mem_clear;
    logic [31:0] mem_arr [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        cv, cwe;
        logic [31:0] caddr, cwd;
        logic [3:0]  cm;
        logic        dv, dwe;
        logic [31:0] daddr, dwd;
        logic [3:0]  dm;
        logic        e_crdy, e_drdy, e_men;
        logic [29:0] e_maddr;
        logic        e_cval;
        logic [31:0] e_crd;
        logic        e_dval;
        logic [31:0] e_drd;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] pre [0:5] = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd7, 32'd2};

    // reference model state
    int          m_wait;
    logic        exp_pv, exp_po, last_gc, last_gd;
    logic [31:0] exp_pd;
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_we(core_req_we),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata), .core_req_wmask(core_req_wmask),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
        .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata), .dbg_req_wmask(dbg_req_wmask),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous memory: writes commit on the edge, reads return next cycle.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) mem_arr[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem_arr[mem_addr[5:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_core(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        core_req_valid = v; core_req_we = we; core_req_addr = a; core_req_wdata = d; core_req_wmask = m;
    endtask

    task automatic set_dbg(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        dbg_req_valid = v; dbg_req_we = we; dbg_req_addr = a; dbg_req_wdata = d; dbg_req_wmask = m;
    endtask

    task automatic idle();
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic cv, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd, input logic [3:0] cm,
                       input logic dv, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd, input logic [3:0] dm,
                       input logic ecr, input logic edr, input logic emen, input logic [29:0] emaddr,
                       input logic ecv, input logic [31:0] ecd, input logic edv, input logic [31:0] edd);
        vec_t v;
        v.cv = cv; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd; v.cm = cm;
        v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.dm = dm;
        v.e_crdy = ecr; v.e_drdy = edr; v.e_men = emen; v.e_maddr = emaddr;
        v.e_cval = ecv; v.e_crd = ecd; v.e_dval = edv; v.e_drd = edd;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rnd_addr();
        return {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
    endfunction

    // Debug wins when it has waited MAX_WAIT cycles or the core is idle; otherwise the core wins.
    task automatic model_cycle(input int k);
        logic        gd, gc, e_en, e_we;
        logic [29:0] e_addr;
        logic [31:0] e_wd, word;
        logic [3:0]  e_m;
        gd = dbg_req_valid && ((m_wait >= MAX_WAIT) || !core_req_valid);
        gc = core_req_valid && !gd;
        e_en = gc || gd; e_we = 1'b0; e_addr = '0; e_wd = '0; e_m = '0;
        if (gc) begin
            e_we = core_req_we; e_addr = core_req_addr[31:2]; e_wd = core_req_wdata; e_m = core_req_wmask;
        end else if (gd) begin
            e_we = dbg_req_we; e_addr = dbg_req_addr[31:2]; e_wd = dbg_req_wdata; e_m = dbg_req_wmask;
        end
        chk($sformatf("rnd%0d core_ready", k), core_req_ready, gc);
        chk($sformatf("rnd%0d dbg_ready", k), dbg_req_ready, gd);
        chk($sformatf("rnd%0d mem_en", k), mem_en, e_en);
        chk($sformatf("rnd%0d mem_we", k), mem_we, e_we);
        chk($sformatf("rnd%0d mem_addr", k), mem_addr, e_addr);
        chk($sformatf("rnd%0d mem_wdata", k), mem_wdata, e_wd);
        chk($sformatf("rnd%0d mem_wmask", k), mem_wmask, e_m);
        chk($sformatf("rnd%0d core_rsp_valid", k), core_rsp_valid, exp_pv && !exp_po);
        chk($sformatf("rnd%0d core_rsp_rdata", k), core_rsp_rdata, (exp_pv && !exp_po) ? exp_pd : 32'h0);
        chk($sformatf("rnd%0d dbg_rsp_valid", k), dbg_rsp_valid, exp_pv && exp_po);
        chk($sformatf("rnd%0d dbg_rsp_rdata", k), dbg_rsp_rdata, (exp_pv && exp_po) ? exp_pd : 32'h0);
        word   = ref_mem[e_addr[5:0]];
        exp_pv = e_en;
        exp_po = gd;
        exp_pd = e_we ? 32'h0 : word;
        if (e_en && e_we)
            for (int b = 0; b < 4; b++)
                if (e_m[b]) ref_mem[e_addr[5:0]][8*b +: 8] = e_wd[8*b +: 8];
        m_wait  = (dbg_req_valid && !gd) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
        last_gc = gc;
        last_gd = gd;
    endtask

    initial begin
        // ---------------- reset held with both requesters active
        rst = 1'b0;
        mem_clear = 1'b1;
        set_core(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        next_cycle();
        mem_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst core_ready", core_req_ready, 1'b0);
            chk("rst dbg_ready", dbg_req_ready, 1'b0);
            chk("rst mem_en", mem_en, 1'b0);
            chk("rst core_rsp_valid", core_rsp_valid, 1'b0);
            chk("rst dbg_rsp_valid", dbg_rsp_valid, 1'b0);
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("release core_ready", core_req_ready, 1'b1);
        chk("release dbg_ready", dbg_req_ready, 1'b0);
        chk("release mem_en", mem_en, 1'b1);
        chk("release mem_addr", mem_addr, 30'd0);
        // reset lands on the edge that would have accepted this read
        rst = 1'b0;
        next_cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst = 1'b1;
            @(negedge clk);
            chk("drop core_rsp_valid", core_rsp_valid, 1'b0);
            chk("drop core_rsp_rdata", core_rsp_rdata, 32'h0);
            chk("drop dbg_rsp_valid", dbg_rsp_valid, 1'b0);
            chk("drop mem_en", mem_en, 1'b0);
            next_cycle();
        end

        // ---------------- directed vector table
        add(0, 0, 32'h0, 32'h0, 4'h0,  1, 1, 32'h0C, 32'd42, 4'hF,  0, 1, 1, 30'd3,  0, 32'h0, 0, 32'h0);
        add(1, 0, 32'h0C, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0,    1, 0, 1, 30'd3,  0, 32'h0, 1, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  0, 0, 32'h0, 32'h0, 4'h0,    0, 0, 0, 30'd0,  1, 32'd42, 0, 32'h0);
        for (int k = 0; k < 6; k++)
            add(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'(4*k), pre[k], 4'hF, 0, 1, 1, 30'(k), 0, 32'h0, (k > 0), 32'h0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] prev;
            prev = 32'h0;
            if (k > 0) prev = pre[k-1];
            add(1, 0, 32'(4*k), 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 30'(k), (k > 0), prev, (k == 0), 32'h0);
        end
        add(0, 0, 32'h0, 32'h0, 4'h0,  0, 0, 32'h0, 32'h0, 4'h0,           0, 0, 0, 30'd0,  1, 32'd2, 0, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  1, 1, 32'h0, 32'hAABBCCDD, 4'hF,    0, 1, 1, 30'd0,  0, 32'h0, 0, 32'h0);
        add(1, 1, 32'h0, 32'h11223344, 4'h5, 0, 0, 32'h0, 32'h0, 4'h0,     1, 0, 1, 30'd0,  0, 32'h0, 1, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  1, 0, 32'h0, 32'h0, 4'h0,           0, 1, 1, 30'd0,  1, 32'h0, 0, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  0, 0, 32'h0, 32'h0, 4'h0,           0, 0, 0, 30'd0,  0, 32'h0, 1, 32'hAA22CC44);
        add(1, 0, 32'h0F, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0,           1, 0, 1, 30'd3,  0, 32'h0, 0, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  0, 0, 32'h0, 32'h0, 4'h0,           0, 0, 0, 30'd0,  1, 32'd1, 0, 32'h0);
        add(1, 0, 32'h04, 32'h0, 4'h0, 1, 0, 32'h08, 32'h0, 4'h0,          1, 0, 1, 30'd1,  0, 32'h0, 0, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  1, 0, 32'h08, 32'h0, 4'h0,          0, 1, 1, 30'd2,  1, 32'd3, 0, 32'h0);
        add(0, 0, 32'h0, 32'h0, 4'h0,  0, 0, 32'h0, 32'h0, 4'h0,           0, 0, 0, 30'd0,  0, 32'h0, 1, 32'd9);
        foreach (tbl[i]) begin
            set_core(tbl[i].cv, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd, tbl[i].cm);
            set_dbg(tbl[i].dv, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd, tbl[i].dm);
            @(negedge clk);
            chk($sformatf("vec%0d core_ready", i), core_req_ready, tbl[i].e_crdy);
            chk($sformatf("vec%0d dbg_ready", i), dbg_req_ready, tbl[i].e_drdy);
            chk($sformatf("vec%0d mem_en", i), mem_en, tbl[i].e_men);
            chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
            chk($sformatf("vec%0d core_rsp_valid", i), core_rsp_valid, tbl[i].e_cval);
            chk($sformatf("vec%0d core_rsp_rdata", i), core_rsp_rdata, tbl[i].e_crd);
            chk($sformatf("vec%0d dbg_rsp_valid", i), dbg_rsp_valid, tbl[i].e_dval);
            chk($sformatf("vec%0d dbg_rsp_rdata", i), dbg_rsp_rdata, tbl[i].e_drd);
            next_cycle();
        end

        // ---------------- starvation: debug forced in every MAX_WAIT+1 cycles
        set_core(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            chk($sformatf("starve%0d core_ready", c), core_req_ready, (c != 4) && (c != 9));
            chk($sformatf("starve%0d dbg_ready", c), dbg_req_ready, (c == 4) || (c == 9));
            chk($sformatf("starve%0d dbg_rsp_valid", c), dbg_rsp_valid, (c == 5) || (c == 10));
            next_cycle();
        end
        idle();
        next_cycle();
        next_cycle();

        // ---------------- write granted just before reset still commits
        set_dbg(1'b1, 1'b1, 32'h28, 32'hCAFE0001, 4'hF);
        @(negedge clk);
        chk("preRst dbg_ready", dbg_req_ready, 1'b1);
        next_cycle();
        rst = 1'b0;
        idle();
        next_cycle();
        rst = 1'b1;
        set_core(1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
        @(negedge clk);
        chk("postRst core_ready", core_req_ready, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("postRst core_rsp_valid", core_rsp_valid, 1'b1);
        chk("postRst core_rsp_rdata", core_rsp_rdata, 32'hCAFE0001);
        next_cycle();

        // ---------------- random traffic against the reference model
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        m_wait = 0; exp_pv = 1'b0; exp_po = 1'b0; exp_pd = 32'h0;
        last_gc = 1'b1; last_gd = 1'b1;
        ref_mem = mem_arr;
        for (int k = 0; k < 600; k++) begin
            if (!core_req_valid || last_gc)
                set_core($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rnd_addr(), 32'($urandom), 4'($urandom));
            if (!dbg_req_valid || last_gd)
                set_dbg($urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)), rnd_addr(), 32'($urandom), 4'($urandom));
            @(negedge clk);
            model_cycle(k);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
